// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// stage-enable and flush bit positions.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MD_WAIT  = 2'd2
  } pipe_state_t;

  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;

  localparam int FL_IF_ID  = 0;
  localparam int FL_ID_EX  = 1;
  localparam int FL_EX_MEM = 2;
  localparam int FL_MEM_WB = 3;

  localparam logic [4:0] STAGE_ALL = 5'b11111;

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Data-memory watchdog timer: start loads 1, clr zeroes, otherwise a running
// timer counts up and saturates at MEM_TIMEOUT-1, where expired is raised.
module pipe_ctrl_wdog #(
  parameter int MEM_TIMEOUT = 64,
  parameter int TMR_W       = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clr,
  output logic expired
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  logic [TMR_W-1:0] timer_q;

  // A zero timer is idle; only start arms it, so it never counts on its own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
    end else if (clr) begin
      timer_q <= '0;
    end else if (start) begin
      timer_q <= TMR_W'(1);
    end else if ((timer_q != '0) && (timer_q != TMR_LAST)) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  assign expired = (timer_q == TMR_LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage core.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int TMR_W       = 7,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_stall,
  input  logic              redirect_EX,
  input  logic              imem_ready,
  input  logic              dmem_req_MEM,
  input  logic              dmem_ready,
  input  logic              md_start_EX,
  input  logic              md_done,
  output logic [4:0]        stage_en,
  output logic [3:0]        flush,
  output logic              mem_timeout,
  output logic [1:0]        state_o,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  pipe_state_t state_q, state_d;
  logic [4:0]  en_c;
  logic [3:0]  fl_c;
  logic        tmr_start, tmr_clr, tmr_expired;
  logic        timeout_d, timeout_q;

  pipe_ctrl_wdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMR_W      (TMR_W)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .start  (tmr_start),
    .clr    (tmr_clr),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  // The RUN branch doubles as the recovery path for the illegal encoding 2'd3.
  always_comb begin
    state_d   = ST_RUN;
    en_c      = STAGE_ALL;
    fl_c      = '0;
    tmr_start = 1'b0;
    tmr_clr   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          tmr_clr = 1'b1;
        end else if (tmr_expired) begin
          fl_c[FL_MEM_WB] = 1'b1;
          timeout_d       = 1'b1;
          tmr_clr         = 1'b1;
        end else begin
          en_c    = '0;
          state_d = ST_MEM_WAIT;
        end
      end
      ST_MD_WAIT: begin
        tmr_clr = 1'b1;
        if (!md_done) begin
          en_c             = '0;
          en_c[STG_MEM_WB] = 1'b1;
          fl_c[FL_EX_MEM]  = 1'b1;
          state_d          = ST_MD_WAIT;
        end
      end
      default: begin
        if (dmem_req_MEM && !dmem_ready) begin
          en_c      = '0;
          state_d   = ST_MEM_WAIT;
          tmr_start = 1'b1;
        end else if (md_start_EX && !md_done) begin
          tmr_clr          = 1'b1;
          en_c             = '0;
          en_c[STG_MEM_WB] = 1'b1;
          fl_c[FL_EX_MEM]  = 1'b1;
          state_d          = ST_MD_WAIT;
        end else begin
          tmr_clr = 1'b1;
          if (redirect_EX) begin
            fl_c[FL_IF_ID] = 1'b1;
            fl_c[FL_ID_EX] = 1'b1;
          end else if (load_stall) begin
            en_c[STG_PC]    = 1'b0;
            en_c[STG_IF_ID] = 1'b0;
            fl_c[FL_ID_EX]  = 1'b1;
          end else if (!imem_ready) begin
            en_c[STG_PC]   = 1'b0;
            fl_c[FL_IF_ID] = 1'b1;
          end
        end
      end
    endcase
  end

  // Reset freezes every register and bubbles the whole pipe immediately.
  assign stage_en    = rst ? en_c : '0;
  assign flush       = rst ? fl_c : 4'b1111;
  assign mem_timeout = timeout_q;
  assign state_o     = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  // Only a redirect produces flush[1:0]==2'b11 while out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!stage_en[STG_PC]) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush[1:0] == 2'b11) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MEM_TIMEOUT=8); perf counters
// are checked against a model when PIPE_CTRL_PERF_EN is defined, else against 0.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_stall, redirect_EX, imem_ready, dmem_req_MEM, dmem_ready;
  logic        md_start_EX, md_done;
  logic [4:0]  stage_en;
  logic [3:0]  flush;
  logic        mem_timeout;
  logic [1:0]  state_o;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_stall = '0;
  logic [31:0] exp_flush = '0;

  pipe_ctrl #(
    .MEM_TIMEOUT(8),
    .TMR_W      (7),
    .PERF_W     (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_stall    (load_stall),
    .redirect_EX   (redirect_EX),
    .imem_ready    (imem_ready),
    .dmem_req_MEM  (dmem_req_MEM),
    .dmem_ready    (dmem_ready),
    .md_start_EX   (md_start_EX),
    .md_done       (md_done),
    .stage_en      (stage_en),
    .flush         (flush),
    .mem_timeout   (mem_timeout),
    .state_o       (state_o),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ls, input logic rd, input logic im,
                               input logic dq, input logic dr, input logic ms,
                               input logic md);
    load_stall   = ls;
    redirect_EX  = rd;
    imem_ready   = im;
    dmem_req_MEM = dq;
    dmem_ready   = dr;
    md_start_EX  = ms;
    md_done      = md;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] e_en,
                             input logic [3:0] e_fl, input logic [1:0] e_st,
                             input logic e_to);
    checks++;
    assert (stage_en === e_en) else begin
      errors++;
      $error("[TB] FAIL %s stage_en got %b exp %b", tag, stage_en, e_en);
    end
    checks++;
    assert (flush === e_fl) else begin
      errors++;
      $error("[TB] FAIL %s flush got %b exp %b", tag, flush, e_fl);
    end
    checks++;
    assert (state_o === e_st) else begin
      errors++;
      $error("[TB] FAIL %s state_o got %0d exp %0d", tag, state_o, e_st);
    end
    checks++;
    assert (mem_timeout === e_to) else begin
      errors++;
      $error("[TB] FAIL %s mem_timeout got %b exp %b", tag, mem_timeout, e_to);
    end
    checks++;
    assert (perf_stall_cnt === exp_stall) else begin
      errors++;
      $error("[TB] FAIL %s perf_stall_cnt got %0d exp %0d", tag, perf_stall_cnt, exp_stall);
    end
    checks++;
    assert (perf_flush_cnt === exp_flush) else begin
      errors++;
      $error("[TB] FAIL %s perf_flush_cnt got %0d exp %0d", tag, perf_flush_cnt, exp_flush);
    end
`ifdef PIPE_CTRL_PERF_EN
    if (!rst) begin
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      if (!e_en[0]) exp_stall = exp_stall + 1;
      if (e_fl[1:0] == 2'b11) exp_flush = exp_flush + 1;
    end
`endif
  endtask

  task automatic step(input string tag, input logic ls, input logic rd,
                      input logic im, input logic dq, input logic dr,
                      input logic ms, input logic md, input logic [4:0] e_en,
                      input logic [3:0] e_fl, input logic [1:0] e_st,
                      input logic e_to);
    @(negedge clk);
    applyStimulus(ls, rd, im, dq, dr, ms, md);
    #1;
    checkOutput(tag, e_en, e_fl, e_st, e_to);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset", 5'b00000, 4'b1111, 2'd0, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("idle", 5'b11111, 4'b0000, 2'd0, 1'b0);

    //      tag            ls rd im dq dr ms md  stage_en  flush    st to
    step("load_use",        1, 0, 1, 0, 0, 0, 0, 5'b11100, 4'b0010, 0, 0);
    step("load_use_rel",    0, 0, 1, 0, 0, 0, 0, 5'b11111, 4'b0000, 0, 0);
    step("redir_vs_load",   1, 1, 0, 0, 0, 0, 0, 5'b11111, 4'b0011, 0, 0);
    step("imem_wait",       0, 0, 0, 0, 0, 0, 0, 5'b11110, 4'b0001, 0, 0);
    step("after_redir",     0, 0, 1, 0, 0, 0, 0, 5'b11111, 4'b0000, 0, 0);

    step("dmem_enter",      0, 0, 1, 1, 0, 0, 0, 5'b00000, 4'b0000, 0, 0);
    for (int i = 0; i < 3; i++)
      step("dmem_wait",     0, 0, 1, 1, 0, 0, 0, 5'b00000, 4'b0000, 1, 0);
    step("dmem_done",       0, 0, 1, 1, 1, 0, 0, 5'b11111, 4'b0000, 1, 0);
    step("dmem_after",      0, 0, 1, 0, 0, 0, 0, 5'b11111, 4'b0000, 0, 0);

    step("wdog_enter",      0, 0, 1, 1, 0, 0, 0, 5'b00000, 4'b0000, 0, 0);
    for (int i = 0; i < 6; i++)
      step("wdog_wait",     0, 0, 1, 1, 0, 0, 0, 5'b00000, 4'b0000, 1, 0);
    step("wdog_abort",      0, 0, 1, 1, 0, 0, 0, 5'b11111, 4'b1000, 1, 0);
    step("wdog_pulse",      0, 0, 1, 0, 0, 0, 0, 5'b11111, 4'b0000, 0, 1);
    step("wdog_pulse_end",  0, 0, 1, 0, 0, 0, 0, 5'b11111, 4'b0000, 0, 0);

    step("md_enter",        0, 0, 1, 0, 0, 1, 0, 5'b10000, 4'b0100, 0, 0);
    for (int i = 0; i < 4; i++)
      step("md_wait",       1, 1, 1, 0, 0, 1, 0, 5'b10000, 4'b0100, 2, 0);
    step("md_done",         0, 0, 1, 0, 0, 0, 1, 5'b11111, 4'b0000, 2, 0);
    step("md_after",        0, 0, 1, 0, 0, 0, 0, 5'b11111, 4'b0000, 0, 0);
    step("md_single",       0, 0, 1, 0, 0, 1, 1, 5'b11111, 4'b0000, 0, 0);
    step("md_single_after", 0, 0, 1, 0, 0, 0, 0, 5'b11111, 4'b0000, 0, 0);

    step("memw_enter",      0, 0, 1, 1, 0, 0, 0, 5'b00000, 4'b0000, 0, 0);
    step("memw_ignore",     1, 1, 1, 1, 0, 1, 0, 5'b00000, 4'b0000, 1, 0);
    step("memw_done",       1, 1, 1, 1, 1, 0, 0, 5'b11111, 4'b0000, 1, 0);
    step("memw_after",      0, 0, 1, 0, 0, 0, 0, 5'b11111, 4'b0000, 0, 0);

    step("mdrst_enter",     0, 0, 1, 0, 0, 1, 0, 5'b10000, 4'b0100, 0, 0);
    step("mdrst_wait",      0, 0, 1, 0, 0, 1, 0, 5'b10000, 4'b0100, 2, 0);
    @(negedge clk);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("mdrst_reset", 5'b00000, 4'b1111, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mdrst_release", 5'b11111, 4'b0000, 2'd0, 1'b0);
    step("mdrst_run",       0, 0, 1, 0, 0, 0, 0, 5'b11111, 4'b0000, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
